// File: rtl/alu_pwr_pkg.sv
// Shared types and default timing constants for the ALU power-domain sequencer.
package alu_pwr_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    PWR_UP  = 2'd1,
    ON      = 2'd2,
    ISO_SET = 2'd3
  } pwr_state_t;

  localparam int DEF_PWRUP_CYC = 4;
  localparam int DEF_ISO_CYC   = 2;
  localparam int DEF_IDLE_CYC  = 16;
  // Wide enough for the largest idle timeout (65535).
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter shared by the power-up, idle and isolation phases.
// done flags the last cycle of a loaded interval (count == 1).
module alu_pwr_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= value;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/alu_pwr_seq_ctrl.sv
// Power-gating sequencer for the ALU domain: orders power/isolation, wakes on
// request, issues start pulses while ON and powers down on idle or sleep.
module alu_pwr_seq_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int PWRUP_CYC = DEF_PWRUP_CYC,
  parameter int ISO_CYC   = DEF_ISO_CYC,
  parameter int IDLE_CYC  = DEF_IDLE_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       sleep_req,
  input  logic       alu_busy,
  output logic       alu_start,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic [1:0] pwr_state,
  output logic       pwr_ack
);

  pwr_state_t       state_reg, state_next;
  logic             req_ready_reg, alu_start_reg, start_guard_reg;
  logic             alu_pwr_en_reg, iso_en_reg, pwr_ack_reg;
  logic             hs, guard_now;
  logic             timer_load, timer_done;
  logic [CNT_W-1:0] timer_val;

  assign hs        = req_valid && req_ready_reg;
  // The start cycle and the cycle after it hide the ALU's busy latency.
  assign guard_now = alu_start_reg || start_guard_reg;

  alu_pwr_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_val),
    .done  (timer_done)
  );

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_reg)
      OFF: begin
        if (req_valid && !sleep_req) begin
          state_next = PWR_UP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(PWRUP_CYC);
        end
      end
      PWR_UP: begin
        if (timer_done) begin
          state_next = ON;
          timer_load = 1'b1;
          timer_val  = CNT_W'(IDLE_CYC);
        end
      end
      ON: begin
        // A handshake or an in-flight operation always keeps the domain up.
        if (hs || alu_busy || guard_now) begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(IDLE_CYC);
        end else if (sleep_req || timer_done) begin
          state_next = ISO_SET;
          timer_load = 1'b1;
          timer_val  = CNT_W'(ISO_CYC);
        end
      end
      ISO_SET: begin
        if (timer_done) begin
          state_next = OFF;
        end
      end
      default: state_next = OFF;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= OFF;
      alu_pwr_en_reg  <= 1'b0;
      iso_en_reg      <= 1'b1;
      req_ready_reg   <= 1'b0;
      alu_start_reg   <= 1'b0;
      start_guard_reg <= 1'b0;
      pwr_ack_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      alu_pwr_en_reg  <= (state_next != OFF);
      iso_en_reg      <= (state_next != ON);
      pwr_ack_reg     <= (state_next == ON);
      alu_start_reg   <= hs;
      start_guard_reg <= alu_start_reg;
      req_ready_reg   <= (state_next == ON) && !alu_busy && !sleep_req &&
                         !hs && !guard_now;
    end
  end

  assign req_ready  = req_ready_reg;
  assign alu_start  = alu_start_reg;
  assign alu_pwr_en = alu_pwr_en_reg;
  assign iso_en     = iso_en_reg;
  assign pwr_ack    = pwr_ack_reg;
  assign pwr_state  = state_reg;

endmodule

// File: tb/tb_alu_pwr_seq_ctrl.sv
// Directed bench for alu_pwr_seq_ctrl with PWRUP_CYC=4, ISO_CYC=2, IDLE_CYC=16.
module tb_alu_pwr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       sleep_req;
  logic       alu_busy;
  logic       alu_start;
  logic       alu_pwr_en;
  logic       iso_en;
  logic [1:0] pwr_state;
  logic       pwr_ack;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_pwr_seq_ctrl #(
    .PWRUP_CYC (4),
    .ISO_CYC   (2),
    .IDLE_CYC  (16),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .sleep_req  (sleep_req),
    .alu_busy   (alu_busy),
    .alu_start  (alu_start),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .pwr_state  (pwr_state),
    .pwr_ack    (pwr_ack)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample 1 time unit after the edge and check the
  // isolation invariant every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    assert (alu_pwr_en || iso_en) else begin
      errors++;
      $error("FAIL iso_invariant cyc=%0d observed pwr_en=%0b iso_en=%0b required iso_en=1",
             cyc, alu_pwr_en, iso_en);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic pwr,
                         input logic iso, input logic rdy, input logic start);
    chk({tag, ".state"}, pwr_state, st);
    chk({tag, ".pwr_en"}, {1'b0, alu_pwr_en}, {1'b0, pwr});
    chk({tag, ".iso_en"}, {1'b0, iso_en}, {1'b0, iso});
    chk({tag, ".ready"}, {1'b0, req_ready}, {1'b0, rdy});
    chk({tag, ".start"}, {1'b0, alu_start}, {1'b0, start});
    chk({tag, ".ack"}, {1'b0, pwr_ack}, {1'b0, (st == 2'd2)});
    $display("cyc=%0d %s state=%0d pwr_en=%0b iso=%0b ready=%0b start=%0b ack=%0b",
             cyc, tag, pwr_state, alu_pwr_en, iso_en, req_ready, alu_start, pwr_ack);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; sleep_req = 1'b0; alu_busy = 1'b0;
    tick(); tick();
    chk_all("reset", 2'd0, 0, 1, 0, 0);
    rst = 1'b0;
    tick();
    cyc = 0;
    // Cold wake: request at cycle 0
    req_valid = 1'b1;
    tick(); chk_all("wake_pwr_en", 2'd1, 1, 1, 0, 0);
    repeat (3) begin tick(); chk_all("wake_iso_hold", 2'd1, 1, 1, 0, 0); end
    tick(); chk_all("wake_on", 2'd2, 1, 0, 1, 0);
    tick(); chk_all("wake_start", 2'd2, 1, 0, 0, 1);
    // Second request held; ALU busy for cycles 7..16
    tick(); chk_all("start_guard", 2'd2, 1, 0, 0, 0);
    alu_busy = 1'b1;
    repeat (9) begin tick(); chk_all("busy_hold", 2'd2, 1, 0, 0, 0); end
    tick(); chk_all("busy_tail", 2'd2, 1, 0, 0, 0);
    alu_busy = 1'b0;
    tick(); chk_all("busy_done_ready", 2'd2, 1, 0, 1, 0);
    tick(); chk_all("second_start", 2'd2, 1, 0, 0, 1);
    req_valid = 1'b0;
    // Idle power-down
    repeat (2) begin tick(); chk_all("post_start_guard", 2'd2, 1, 0, 0, 0); end
    repeat (15) begin tick(); chk_all("idle_on", 2'd2, 1, 0, 1, 0); end
    repeat (2) begin tick(); chk_all("idle_iso_set", 2'd3, 1, 1, 0, 0); end
    tick(); chk_all("idle_off", 2'd0, 0, 1, 0, 0);
    // Sleep while busy
    req_valid = 1'b1;
    tick(); chk_all("wake2_pwr_up", 2'd1, 1, 1, 0, 0);
    repeat (3) tick();
    tick(); chk_all("wake2_on", 2'd2, 1, 0, 1, 0);
    tick(); chk_all("wake2_start", 2'd2, 1, 0, 0, 1);
    req_valid = 1'b0;
    tick(); alu_busy = 1'b1;
    tick(); sleep_req = 1'b1;
    repeat (3) begin tick(); chk_all("sleep_wait_busy", 2'd2, 1, 0, 0, 0); end
    tick(); chk_all("sleep_last_busy", 2'd2, 1, 0, 0, 0);
    alu_busy = 1'b0;
    repeat (2) begin tick(); chk_all("sleep_iso_set", 2'd3, 1, 1, 0, 0); end
    tick(); chk_all("sleep_off", 2'd0, 0, 1, 0, 0);
    req_valid = 1'b1;
    repeat (2) begin tick(); chk_all("sleep_inhibit_wake", 2'd0, 0, 1, 0, 0); end
    sleep_req = 1'b0;
    tick(); chk_all("sleep_release_wake", 2'd1, 1, 1, 0, 0);
    req_valid = 1'b0;
    repeat (3) tick();
    // Request coincides with idle expiry
    tick(); chk_all("wake3_on", 2'd2, 1, 0, 1, 0);
    repeat (14) begin tick(); chk_all("wake3_idle", 2'd2, 1, 0, 1, 0); end
    tick(); chk_all("expiry_cycle", 2'd2, 1, 0, 1, 0);
    req_valid = 1'b1;
    tick(); chk_all("expiry_req_wins", 2'd2, 1, 0, 0, 1);
    req_valid = 1'b0;
    repeat (2) begin tick(); chk_all("wake3_guard", 2'd2, 1, 0, 0, 0); end
    repeat (15) begin tick(); chk_all("wake3_idle2", 2'd2, 1, 0, 1, 0); end
    // Request arriving during ISO_SET is served after OFF
    tick(); chk_all("isoreq_iso1", 2'd3, 1, 1, 0, 0);
    req_valid = 1'b1;
    tick(); chk_all("isoreq_iso2", 2'd3, 1, 1, 0, 0);
    tick(); chk_all("isoreq_off", 2'd0, 0, 1, 0, 0);
    tick(); chk_all("isoreq_rewake", 2'd1, 1, 1, 0, 0);
    // Reset mid-PWR_UP
    tick(); chk_all("pre_rst_pwr_up", 2'd1, 1, 1, 0, 0);
    rst = 1'b1;
    tick(); chk_all("rst_mid_pwr_up", 2'd0, 0, 1, 0, 0);
    rst = 1'b0;
    tick(); chk_all("post_rst_wake", 2'd1, 1, 1, 0, 0);
    repeat (3) tick();
    tick(); chk_all("wake4_on", 2'd2, 1, 0, 1, 0);
    tick(); chk_all("wake4_start", 2'd2, 1, 0, 0, 1);
    req_valid = 1'b0;
    sleep_req = 1'b1;
    repeat (2) begin tick(); chk_all("sleep_masked_by_guard", 2'd2, 1, 0, 0, 0); end
    // Reset mid-ISO_SET
    tick(); chk_all("pre_rst_iso_set", 2'd3, 1, 1, 0, 0);
    rst = 1'b1;
    tick(); chk_all("rst_mid_iso_set", 2'd0, 0, 1, 0, 0);
    rst = 1'b0;
    tick(); chk_all("post_rst_off", 2'd0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
